// File: rtl/com_uart_responder_if.sv
// CPU communications-port bundle for com_uart_responder.
// The CPU side (master) drives address, strobes and write data; the
// responder (slave) returns combinational read data.
interface com_uart_responder_if;
  logic [7:0] addr;
  logic       we;
  logic       re;
  logic [7:0] wr;
  logic [7:0] rd;

  modport master (output addr, we, re, wr, input rd);
  modport slave  (input addr, we, re, wr, output rd);
endinterface

// File: rtl/com_uart_responder.sv
// Memory-mapped 8N1 UART responder on the processor communications port.
// TX and RX byte FIFOs sit between the CPU register map and the serialisers.
// Optional build macro: COM_UART_LOOPBACK_EN feeds the RX path from uart_tx
// instead of the uart_rx pin.
module com_uart_responder #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic                clk,
  input  logic                rst,
  com_uart_responder_if.slave com,
  input  logic                uart_rx,
  output logic                uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [7:0] A_DATA    = 8'h01;
  localparam logic [7:0] A_STATUS  = 8'h02;
  localparam logic [7:0] A_BAUD_LO = 8'h03;
  localparam logic [7:0] A_BAUD_HI = 8'h04;
  localparam logic [7:0] A_CTRL    = 8'h05;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Register decode
  logic wr_data, rd_data, wr_ctrl_clr;
  assign wr_data     = com.we && (com.addr == A_DATA);
  assign rd_data     = com.re && (com.addr == A_DATA);
  assign wr_ctrl_clr = com.we && (com.addr == A_CTRL) && com.wr[0];

  // Baud divisor; values below 3 run as 3 but read back as written
  logic [15:0] divisor, eff_div, half_m1;
  assign eff_div = (divisor < 16'd3) ? 16'd3 : divisor;
  assign half_m1 = (eff_div - 16'd1) >> 1;  // (div+1)/2 - 1

  // Divisor register writes
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      divisor <= DIV_RESET;
    end else if (com.we) begin
      if (com.addr == A_BAUD_LO) divisor[7:0]  <= com.wr;
      if (com.addr == A_BAUD_HI) divisor[15:8] <= com.wr;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr;
  logic [CW-1:0] tx_count;
  logic          tx_full, tx_push, tx_pop, tx_drop_set;
  logic [1:0]    tx_state;
  logic [15:0]   tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;

  assign tx_full     = (tx_count == FULL_CNT);
  assign tx_pop      = (tx_count != '0) &&
                       ((tx_state == ST_IDLE) || (tx_state == ST_STOP && tx_cnt == 16'd0));
  assign tx_push     = wr_data && (!tx_full || tx_pop);
  assign tx_drop_set = wr_data && tx_full && !tx_pop;

  // TX FIFO storage
  always_ff @(posedge clk) begin
    // NOTE: FIFO storage is deliberately not reset; the pointers and count
    // define which entries are valid, so stale contents are never observed.
    if (tx_push) tx_mem[tx_wptr] <= com.wr;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
    end
  end

  // TX serialiser: each state holds for divisor+1 clocks, frames chain with no gap
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_sh    <= tx_mem[tx_rptr];
            tx_cnt   <= eff_div;
            uart_tx  <= 1'b0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt == 16'd0) begin
            uart_tx  <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= eff_div;
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= eff_div;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              uart_tx <= tx_sh[0];
              tx_sh   <= {1'b0, tx_sh[7:1]};
              tx_bit  <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: begin  // ST_STOP
          if (tx_cnt == 16'd0) begin
            if (tx_pop) begin
              tx_sh    <= tx_mem[tx_rptr];
              tx_cnt   <= eff_div;
              uart_tx  <= 1'b0;
              tx_state <= ST_START;
            end else begin
              tx_state <= ST_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic rx_src;
`ifdef COM_UART_LOOPBACK_EN
  assign rx_src = uart_tx;
`else
  assign rx_src = uart_rx;
`endif

  logic rx_s1, rx_s2, rx_prev;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_src;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_done;

  // The stop bit is sampled on the edge where the STOP count expires
  assign rx_done = (rx_state == ST_STOP) && (rx_cnt == 16'd0);

  // RX deserialiser: mid-bit sampling, glitch rejection on the start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= half_m1;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt == 16'd0) begin
            if (rx_s2) begin
              rx_state <= ST_IDLE;
            end else begin
              rx_cnt   <= eff_div;
              rx_bit   <= '0;
              rx_state <= ST_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= eff_div;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: begin  // ST_STOP
          if (rx_cnt == 16'd0) rx_state <= ST_IDLE;
          else                 rx_cnt   <= rx_cnt - 16'd1;
        end
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr, rx_rptr;
  logic [CW-1:0] rx_count;
  logic          rx_full, rx_valid, rx_push, rx_pop, overrun_set, frame_set;

  assign rx_full     = (rx_count == FULL_CNT);
  assign rx_valid    = (rx_count != '0);
  assign rx_pop      = rd_data && rx_valid;
  assign rx_push     = rx_done && (!rx_full || rx_pop);
  assign overrun_set = rx_done && rx_full && !rx_pop;
  assign frame_set   = rx_done && !rx_s2;

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_sh;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
    end
  end

  // ---------------- Sticky flags ----------------
  logic flag_overrun, flag_frame, flag_drop;

  // Sticky error flags; a set in the same cycle as a CTRL clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_overrun <= 1'b0;
      flag_frame   <= 1'b0;
      flag_drop    <= 1'b0;
    end else begin
      flag_overrun <= overrun_set || (flag_overrun && !wr_ctrl_clr);
      flag_frame   <= frame_set   || (flag_frame   && !wr_ctrl_clr);
      flag_drop    <= tx_drop_set || (flag_drop    && !wr_ctrl_clr);
    end
  end

  // ---------------- Read mux ----------------
  logic [7:0] status, rd_mux;
  assign status = {2'b00, flag_drop, flag_frame, flag_overrun, rx_valid,
                   (tx_count == '0) && (tx_state == ST_IDLE), tx_full};

  // Combinational read data, zero unless a read strobe hits a readable register
  always_comb begin
    // NOTE: default assignment first so no path through this block holds a
    // previous value, which would otherwise infer a latch.
    rd_mux = 8'h00;
    if (com.re) begin
      case (com.addr)
        A_DATA:    rd_mux = rx_valid ? rx_mem[rx_rptr] : 8'h00;
        A_STATUS:  rd_mux = status;
        A_BAUD_LO: rd_mux = divisor[7:0];
        A_BAUD_HI: rd_mux = divisor[15:8];
        default:   rd_mux = 8'h00;
      endcase
    end
  end

  assign com.rd = rd_mux;

endmodule

// File: tb/tb_com_uart_responder.sv
// Self-checking bench for com_uart_responder: a register-access vector table
// plus directed TX/RX frame sequences at small divisors.
module tb_com_uart_responder;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx;
  logic uart_tx;

  com_uart_responder_if bus();

  com_uart_responder #(.FIFO_DEPTH(8), .DIV_RESET(16'd433)) dut (
    .clk    (clk),
    .rst    (rst),
    .com    (bus),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] addr;
    logic [7:0] wr;
    logic [7:0] exp_rd;
    string      name;
  } vec_t;

  vec_t vecs[15];
  logic [7:0] burst[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n clocks, landing 1 time unit after the rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    bus.addr = a;
    bus.we   = 1'b1;
    bus.wr   = d;
    step(1);
    bus.we   = 1'b0;
    bus.addr = 8'h00;
    bus.wr   = 8'h00;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
    bus.addr = a;
    bus.re   = 1'b1;
    #2 d = bus.rd;
    step(1);
    bus.re   = 1'b0;
    bus.addr = 8'h00;
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    cpu_read(a, d);
    check(name, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic apply_vec(input vec_t v);
    logic [7:0] d;
    bus.addr = v.addr;
    bus.we   = v.we;
    bus.re   = v.re;
    bus.wr   = v.wr;
    #2 d = bus.rd;
    check(v.name, {24'h0, d}, {24'h0, v.exp_rd});
    step(1);
    bus.we   = 1'b0;
    bus.re   = 1'b0;
    bus.addr = 8'h00;
    bus.wr   = 8'h00;
  endtask

  // Drive one 8N1 frame on uart_rx with the given stop-bit level
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_clks);
    uart_rx = 1'b0;
    step(bit_clks);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      step(bit_clks);
    end
    uart_rx = stop_bit;
    step(bit_clks);
    uart_rx = 1'b1;
    step(4);
  endtask

  // CPU side of the burst: 9 back-to-back writes, then one write into a full FIFO
  task automatic burst_writer();
    for (int i = 0; i < 9; i++) cpu_write(8'h01, burst[i]);
    read_check("burst_status_full", 8'h02, 8'h01);
    cpu_write(8'h01, burst[9]);
    read_check("burst_status_drop", 8'h02, 8'h21);
  endtask

  // Serial side of the burst: decode 9 gapless frames at 4 clocks per bit
  task automatic tx_capture();
    for (int i = 0; i < 20 && uart_tx !== 1'b0; i++) step(1);
    check("burst_start_seen", {31'h0, uart_tx}, 32'h0);
    step(1);
    for (int j = 0; j < 9; j++) begin
      logic [9:0] f;
      for (int k = 0; k < 10; k++) begin
        f[k] = uart_tx;
        step(4);
      end
      check($sformatf("burst_frame%0d", j), {22'h0, f}, {22'h0, 1'b1, burst[j], 1'b0});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] exp_frame;

    // Register-access table: reset state, unmapped addresses, divisor R/W
    vecs[0]  = '{1'b0, 1'b1, 8'h02, 8'h00, 8'h02, "rst_status"};
    vecs[1]  = '{1'b0, 1'b1, 8'h03, 8'h00, 8'hB1, "rst_baud_lo"};
    vecs[2]  = '{1'b0, 1'b1, 8'h04, 8'h00, 8'h01, "rst_baud_hi"};
    vecs[3]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h00, "rst_data_empty"};
    vecs[4]  = '{1'b0, 1'b1, 8'h05, 8'h00, 8'h00, "ctrl_write_only"};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, "addr0_read"};
    vecs[6]  = '{1'b1, 1'b0, 8'h06, 8'hFF, 8'h00, "unmapped_write"};
    vecs[7]  = '{1'b0, 1'b1, 8'h06, 8'h00, 8'h00, "unmapped_read"};
    vecs[8]  = '{1'b1, 1'b0, 8'h03, 8'h01, 8'h00, "wr_baud_lo_1"};
    vecs[9]  = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h01, "rd_baud_lo_1"};
    vecs[10] = '{1'b1, 1'b0, 8'h04, 8'h00, 8'h00, "wr_baud_hi_0"};
    vecs[11] = '{1'b0, 1'b1, 8'h04, 8'h00, 8'h00, "rd_baud_hi_0"};
    vecs[12] = '{1'b1, 1'b0, 8'h03, 8'h03, 8'h00, "wr_baud_lo_3"};
    vecs[13] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h03, "rd_baud_lo_3"};
    vecs[14] = '{1'b0, 1'b1, 8'h02, 8'h00, 8'h02, "status_after_regs"};

    for (int i = 0; i < 10; i++) burst[i] = 8'hC0 + 8'(i * 3);

    bus.addr = 8'h00;
    bus.we   = 1'b0;
    bus.re   = 1'b0;
    bus.wr   = 8'h00;
    uart_rx  = 1'b1;
    rst      = 1'b1;
    step(3);
    rst = 1'b0;
    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);

    for (int i = 0; i < 15; i++) apply_vec(vecs[i]);

    // Single frame 0x55 at divisor 3: start at E1, 4 clocks per bit
    cpu_write(8'h01, 8'h55);
    check("tx55_idle_at_e0", {31'h0, uart_tx}, 32'h1);
    step(1);
    check("tx55_fall_at_e1", {31'h0, uart_tx}, 32'h0);
    step(1);
    exp_frame = 10'b10_0101_0101 << 0;
    exp_frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx55_bit%0d", k), {31'h0, uart_tx}, {31'h0, exp_frame[k]});
      if (k != 9) step(4);
    end
    step(2);
    read_check("tx55_busy_in_stop", 8'h02, 8'h00);
    read_check("tx55_empty_after_40", 8'h02, 8'h02);

    // Nine back-to-back frames plus one dropped write
    fork
      burst_writer();
      tx_capture();
    join
    read_check("burst_done_status", 8'h02, 8'h22);
    cpu_write(8'h05, 8'h01);
    read_check("burst_drop_cleared", 8'h02, 8'h02);

    // RX at divisor 7
    cpu_write(8'h03, 8'h07);
    send_frame(8'hA3, 1'b1, 8);
    read_check("rx_a3_valid", 8'h02, 8'h06);
    read_check("rx_a3_data", 8'h01, 8'hA3);
    read_check("rx_a3_popped", 8'h02, 8'h02);
    read_check("rx_empty_read", 8'h01, 8'h00);

    // 3-clock glitch must not produce a byte
    uart_rx = 1'b0;
    step(3);
    uart_rx = 1'b1;
    step(20);
    read_check("rx_glitch_status", 8'h02, 8'h02);

    // Overrun: nine frames into an 8-deep FIFO
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b1, 8);
    read_check("rx_overrun_status", 8'h02, 8'h0E);
    for (int i = 0; i < 8; i++)
      read_check($sformatf("rx_overrun_byte%0d", i), 8'h01, 8'h10 + 8'(i));
    read_check("rx_drained_status", 8'h02, 8'h0A);
    cpu_write(8'h05, 8'h01);
    read_check("rx_overrun_cleared", 8'h02, 8'h02);

    // Framing error: stop bit low, byte still delivered
    send_frame(8'h3C, 1'b0, 8);
    read_check("rx_frame_err_status", 8'h02, 8'h16);
    read_check("rx_frame_err_data", 8'h01, 8'h3C);
    cpu_write(8'h05, 8'h01);
    read_check("rx_frame_err_cleared", 8'h02, 8'h02);

    // Reset in the middle of a TX frame
    cpu_write(8'h01, 8'h00);
    step(20);
    check("midframe_tx_low", {31'h0, uart_tx}, 32'h0);
    rst = 1'b1;
    step(1);
    check("midframe_rst_tx_high", {31'h0, uart_tx}, 32'h1);
    step(1);
    rst = 1'b0;
    read_check("post_rst_status", 8'h02, 8'h02);
    read_check("post_rst_baud_lo", 8'h03, 8'hB1);
    read_check("post_rst_baud_hi", 8'h04, 8'h01);
    step(5);
    check("post_rst_tx_idle", {31'h0, uart_tx}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
